cfg_chain_ctrl: RTL and testbench

Parametrised configuration loader for the tinyFPGA fabric. It replaces the raw progClk/progDataIn scan chain with a framed protocol. A frame consists of a sync word, CFG_BITS of payload shifted LANES bits per cycle, and an XOR checksum word. The payload lands in a shadow register and is committed atomically to the fabric configuration only if the checksum matches. During each load, the previously committed configuration is shifted out on progDataOut for readback.

---
 rtl/cfg_chain_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cfg_chain_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_ctrl.sv
// ---------------------------------------------------------------------------
// cfg_chain_ctrl
// Framed configuration loader for the tinyFPGA fabric. A frame is a sync
// word, CFG_BITS of payload shifted LANES bits per enabled cycle, and an XOR
// checksum word. The payload collects in a shadow register and is committed
// to the fabric configuration only when the checksum matches. While a new
// payload shifts in, the previously committed configuration shifts out on
// progDataOut so it can be read back.
//
// Ports:
//   progClk      in   1         clock, all state updates on rising edge
//   progRst      in   1         synchronous active-high reset
//   progEn       in   1         shift enable, all state holds when low
//   progDataIn   in   LANES     serial payload lanes
//   progDataOut  out  LANES     readback lanes (previous configuration)
//   cfgOut       out  CFG_BITS  committed configuration to the fabric
//   cfgValid     out  1         high once any frame has committed
//   commitPulse  out  1         one-cycle pulse per successful commit
//   busy         out  1         high while shifting payload or checking
//   error        out  1         sticky checksum-failure flag
// ---------------------------------------------------------------------------
module cfg_chain_ctrl #(
    parameter int                CFG_BITS  = 64,
    parameter int                LANES     = 1,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
    input  logic                progClk,
    input  logic                progRst,
    input  logic                progEn,
    input  logic [LANES-1:0]    progDataIn,
    output logic [LANES-1:0]    progDataOut,
    output logic [CFG_BITS-1:0] cfgOut,
    output logic                cfgValid,
    output logic                commitPulse,
    output logic                busy,
    output logic                error
);

    localparam int WORDS = CFG_BITS / LANES;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [SYNC_W-1:0]   r_syncReg;
    logic [CFG_BITS-1:0] r_shadow;
    logic [CNT_W-1:0]    r_count;
    logic [LANES-1:0]    r_xorAcc;
    logic [CFG_BITS-1:0] r_cfg;
    logic                r_cfgValid;
    logic                r_commitPulse;
    logic                r_error;

    logic [SYNC_W-1:0]   w_syncNext;
    logic [CFG_BITS-1:0] w_shadowNext;
    logic                w_syncHit;
    logic                w_lastWord;
    logic                w_sumOk;

    // Shift helpers are written as shift-and-or so they stay legal even when
    // the sync word or payload is exactly one lane-word wide.
    assign w_syncNext   = (r_syncReg << LANES) | SYNC_W'(progDataIn);
    assign w_shadowNext = (r_shadow << LANES) | CFG_BITS'(progDataIn);
    assign w_syncHit    = (w_syncNext == SYNC_WORD);
    assign w_lastWord   = (r_count == CNT_W'(WORDS - 1));
    assign w_sumOk      = (progDataIn == r_xorAcc);

    // State register; the next-state logic already holds the state when
    // progEn is low, so only reset needs handling here.
    always_ff @(posedge progClk) begin
        if (progRst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Sync matching only happens in HUNT, so a sync pattern
    // inside the payload is ordinary data.
    always_comb begin
        w_nextState = r_state;
        if (progEn) begin
            case (r_state)
                HUNT:    if (w_syncHit)  w_nextState = SHIFT;
                SHIFT:   if (w_lastWord) w_nextState = CHECK;
                CHECK:   w_nextState = HUNT;
                default: w_nextState = HUNT;
            endcase
        end
    end

    // Moore outputs. Readback is the top lane-word of the shadow register,
    // which was preloaded with the old configuration at sync detect, so the
    // old configuration leaves MSB-word first aligned with incoming words.
    always_comb begin
        busy        = 1'b0;
        progDataOut = '0;
        case (r_state)
            SHIFT: begin
                busy        = 1'b1;
                progDataOut = r_shadow[CFG_BITS-1 -: LANES];
            end
            CHECK:   busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath: sync hunter, shadow/count/checksum accumulation and the
    // atomic commit. commitPulse is cleared every cycle it is not set, so it
    // lasts exactly one cycle even if progEn drops right after the commit.
    always_ff @(posedge progClk) begin
        if (progRst) begin
            r_syncReg     <= '0;
            r_shadow      <= '0;
            r_count       <= '0;
            r_xorAcc      <= '0;
            r_cfg         <= '0;
            r_cfgValid    <= 1'b0;
            r_commitPulse <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_commitPulse <= 1'b0;
            if (progEn) begin
                case (r_state)
                    HUNT: begin
                        if (w_syncHit) begin
                            r_shadow  <= r_cfg;
                            r_count   <= '0;
                            r_xorAcc  <= '0;
                            r_error   <= 1'b0;
                            r_syncReg <= '0;
                        end else begin
                            r_syncReg <= w_syncNext;
                        end
                    end
                    SHIFT: begin
                        r_shadow <= w_shadowNext;
                        r_xorAcc <= r_xorAcc ^ progDataIn;
                        r_count  <= r_count + CNT_W'(1);
                    end
                    CHECK: begin
                        if (w_sumOk) begin
                            r_cfg         <= r_shadow;
                            r_cfgValid    <= 1'b1;
                            r_commitPulse <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cfgOut      = r_cfg;
    assign cfgValid    = r_cfgValid;
    assign commitPulse = r_commitPulse;
    assign error       = r_error;

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cfg_chain_ctrl
// Directed bench for cfg_chain_ctrl. Two instances share one clock: a
// 16-bit single-lane loader and a 16-bit four-lane loader. Inputs change
// 1 time unit after the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_cfg_chain_ctrl;

    logic        clk;

    logic        rst1;
    logic        en1;
    logic        din1;
    logic        dout1;
    logic [15:0] cfg1;
    logic        valid1;
    logic        pulse1;
    logic        busy1;
    logic        err1;

    logic        rst4;
    logic        en4;
    logic [3:0]  din4;
    logic [3:0]  dout4;
    logic [15:0] cfg4;
    logic        valid4;
    logic        pulse4;
    logic        busy4;
    logic        err4;

    int assertCount = 0;
    int failCount   = 0;

    cfg_chain_ctrl #(
        .CFG_BITS (16),
        .LANES    (1),
        .SYNC_W   (8),
        .SYNC_WORD(8'hA5)
    ) dut1 (
        .progClk    (clk),
        .progRst    (rst1),
        .progEn     (en1),
        .progDataIn (din1),
        .progDataOut(dout1),
        .cfgOut     (cfg1),
        .cfgValid   (valid1),
        .commitPulse(pulse1),
        .busy       (busy1),
        .error      (err1)
    );

    cfg_chain_ctrl #(
        .CFG_BITS (16),
        .LANES    (4),
        .SYNC_W   (8),
        .SYNC_WORD(8'hA5)
    ) dut4 (
        .progClk    (clk),
        .progRst    (rst4),
        .progEn     (en4),
        .progDataIn (din4),
        .progDataOut(dout4),
        .cfgOut     (cfg4),
        .cfgValid   (valid4),
        .commitPulse(pulse4),
        .busy       (busy4),
        .error      (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle into the single-lane instance.
    task automatic applyStimulus(input logic d, input logic en);
        en1  = en;
        din1 = d;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle into the four-lane instance.
    task automatic applyStimulus4(input logic [3:0] d, input logic en);
        en4  = en;
        din4 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic sendSync1();
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 0; i--) applyStimulus(s[i], 1'b1);
    endtask

    // Shift payload bits hi..lo, checking busy and the readback bit that
    // must be on progDataOut before each word is consumed.
    task automatic sendBits1(input logic [15:0] data, input logic [15:0] old, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            checkOutput("busyShift", 32'(busy1), 32'd1);
            checkOutput("readback", 32'(dout1), 32'(old[i]));
            applyStimulus(data[i], 1'b1);
        end
    endtask

    initial begin
        logic [15:0] w;
        rst1 = 1'b1; en1 = 1'b0; din1 = 1'b0;
        rst4 = 1'b1; en4 = 1'b0; din4 = 4'h0;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: reset state
        checkOutput("rstCfg1",   32'(cfg1),   32'h0);
        checkOutput("rstValid1", 32'(valid1), 32'h0);
        checkOutput("rstPulse1", 32'(pulse1), 32'h0);
        checkOutput("rstErr1",   32'(err1),   32'h0);
        checkOutput("rstBusy1",  32'(busy1),  32'h0);
        checkOutput("rstDout1",  32'(dout1),  32'h0);
        checkOutput("rstCfg4",   32'(cfg4),   32'h0);
        checkOutput("rstBusy4",  32'(busy4),  32'h0);
        rst1 = 1'b0;
        rst4 = 1'b0;

        // Test 2: basic load of BEEF, checksum 1
        applyStimulus(1'b0, 1'b1);
        sendSync1();
        checkOutput("syncBusy", 32'(busy1), 32'd1);
        sendBits1(16'hBEEF, 16'h0000, 15, 0);
        checkOutput("checkBusy", 32'(busy1), 32'd1);
        checkOutput("checkDout", 32'(dout1), 32'd0);
        checkOutput("noEarlyCommit", 32'(cfg1), 32'h0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("cfgBeef",   32'(cfg1),   32'hBEEF);
        checkOutput("validBeef", 32'(valid1), 32'd1);
        checkOutput("pulseBeef", 32'(pulse1), 32'd1);
        checkOutput("idleBusy",  32'(busy1),  32'd0);
        checkOutput("errBeef",   32'(err1),   32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pulseOneCycle", 32'(pulse1), 32'd0);

        // Test 3: readback of BEEF while loading 1234
        sendSync1();
        sendBits1(16'h1234, 16'hBEEF, 15, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("cfg1234",   32'(cfg1),   32'h1234);
        checkOutput("pulse1234", 32'(pulse1), 32'd1);

        // Test 4: bad checksum, then a good frame clears error at sync
        sendSync1();
        sendBits1(16'h1234, 16'h1234, 15, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("badErr",   32'(err1),   32'd1);
        checkOutput("badPulse", 32'(pulse1), 32'd0);
        checkOutput("badCfg",   32'(cfg1),   32'h1234);
        checkOutput("badValid", 32'(valid1), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("errSticky", 32'(err1), 32'd1);
        sendSync1();
        checkOutput("errClearedAtSync", 32'(err1), 32'd0);
        sendBits1(16'hBEEF, 16'h1234, 15, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("recoverCfg", 32'(cfg1), 32'hBEEF);
        checkOutput("recoverErr", 32'(err1), 32'd0);

        // Test 5a: stall for 5 cycles after 8 payload bits of 5A3C (checksum 0)
        sendSync1();
        sendBits1(16'h5A3C, 16'hBEEF, 15, 8);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(k[0], 1'b0);
            checkOutput("stallBusy", 32'(busy1), 32'd1);
            checkOutput("stallDout", 32'(dout1), 32'(1'b1));
            checkOutput("stallCfg",  32'(cfg1),  32'hBEEF);
        end
        sendBits1(16'h5A3C, 16'hBEEF, 7, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stallCommitCfg",   32'(cfg1),   32'h5A3C);
        checkOutput("stallCommitPulse", 32'(pulse1), 32'd1);

        // Test 5b: reset at payload bit 10 with progEn high
        sendSync1();
        sendBits1(16'h1234, 16'h5A3C, 15, 11);
        w = 16'h1234;
        rst1 = 1'b1;
        applyStimulus(w[10], 1'b1);
        rst1 = 1'b0;
        checkOutput("midRstCfg",   32'(cfg1),   32'h0);
        checkOutput("midRstValid", 32'(valid1), 32'd0);
        checkOutput("midRstBusy",  32'(busy1),  32'd0);
        checkOutput("midRstDout",  32'(dout1),  32'd0);
        sendSync1();
        sendBits1(16'hBEEF, 16'h0000, 15, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("postRstCfg", 32'(cfg1), 32'hBEEF);
        applyStimulus(1'b0, 1'b0);

        // Test 6: four lanes, CAFE with checksum 7, then checksum 6
        applyStimulus4(4'hA, 1'b1);
        applyStimulus4(4'h5, 1'b1);
        checkOutput("lanesSyncBusy", 32'(busy4), 32'd1);
        w = 16'hCAFE;
        for (int k = 0; k < 4; k++) begin
            checkOutput("lanesReadback0", 32'(dout4), 32'h0);
            applyStimulus4(w[15-4*k -: 4], 1'b1);
        end
        applyStimulus4(4'h7, 1'b1);
        checkOutput("lanesCfg",   32'(cfg4),   32'hCAFE);
        checkOutput("lanesPulse", 32'(pulse4), 32'd1);
        checkOutput("lanesValid", 32'(valid4), 32'd1);
        applyStimulus4(4'hA, 1'b1);
        applyStimulus4(4'h5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("lanesReadback", 32'(dout4), 32'(w[15-4*k -: 4]));
            applyStimulus4(w[15-4*k -: 4], 1'b1);
        end
        applyStimulus4(4'h6, 1'b1);
        checkOutput("lanesBadErr",   32'(err4),   32'd1);
        checkOutput("lanesBadPulse", 32'(pulse4), 32'd0);
        checkOutput("lanesBadCfg",   32'(cfg4),   32'hCAFE);
        applyStimulus4(4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
